// File: rtl/seq_frame_tx_1101.sv
// seq_frame_tx_1101: serial 1101-preamble frame sender for the 1101 link; `SEQ_TX_PARITY_EN adds an even-parity bit.
// Latency: first preamble bit on dout the cycle after the accept edge; in_ready returns 4+DATA_W(+1)+GAP_CYCLES edges later.
// Backpressure: single word, no buffering; in_ready stays low for the whole frame and upstream must hold in_valid.
module seq_frame_tx_1101 #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_start,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [3:0]       LAST_GAP = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [3:0]       PREAMBLE = 4'b1101;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
`ifdef SEQ_TX_PARITY_EN
  localparam logic [2:0] S_PAR  = 3'd4;
`endif

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [1:0]        pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]        gap_cnt_q, gap_cnt_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              frame_start_q, frame_start_d;
`ifdef SEQ_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif
  logic              accept;
  logic              end_frame;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    pre_cnt_d     = pre_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    in_ready_d    = 1'b0;
    dout_d        = 1'b0;
    dout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    end_frame     = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    parity_d      = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        in_ready_d = !accept;
        if (accept) begin
          // dout is registered, so the first preamble bit is launched on the accept edge itself
          state_d       = S_PRE;
          shift_d       = in_data;
          pre_cnt_d     = 2'd0;
          dout_d        = PREAMBLE[3];
          dout_valid_d  = 1'b1;
          frame_start_d = 1'b1;
`ifdef SEQ_TX_PARITY_EN
          parity_d      = ^in_data;
`endif
        end
      end

      S_PRE: begin
        dout_valid_d = 1'b1;
        if (pre_cnt_q == 2'd3) begin
          state_d   = S_DATA;
          dout_d    = shift_q[DATA_W-1];
          shift_d   = shift_q << 1;
          bit_cnt_d = '0;
        end else begin
          pre_cnt_d = pre_cnt_q + 2'd1;
          dout_d    = PREAMBLE[~pre_cnt_d];
        end
      end

      S_DATA: begin
        if (bit_cnt_q != LAST_BIT) begin
          dout_d       = shift_q[DATA_W-1];
          dout_valid_d = 1'b1;
          shift_d      = shift_q << 1;
          bit_cnt_d    = bit_cnt_q + 1'b1;
        end else begin
`ifdef SEQ_TX_PARITY_EN
          state_d      = S_PAR;
          dout_d       = parity_q;
          dout_valid_d = 1'b1;
`else
          end_frame    = 1'b1;
`endif
        end
      end

`ifdef SEQ_TX_PARITY_EN
      S_PAR: begin
        end_frame = 1'b1;
      end
`endif

      S_GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Leaving the last valid bit: count the frame, then idle gap (or straight to IDLE when there is none)
    if (end_frame) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      gap_cnt_d   = 4'd0;
      if (GAP_CYCLES == 0) begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end else begin
        state_d = S_GAP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      shift_q       <= '0;
      pre_cnt_q     <= 2'd0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= 4'd0;
      frame_cnt_q   <= 8'd0;
      in_ready_q    <= 1'b0;
      dout_q        <= 1'b0;
      dout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      pre_cnt_q     <= pre_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      in_ready_q    <= in_ready_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_start_q <= frame_start_d;
`ifdef SEQ_TX_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_seq_frame_tx_1101.sv
// Directed bench for seq_frame_tx_1101 (DATA_W=8, GAP_CYCLES=2); parity steps run only with SEQ_TX_PARITY_EN.
module tb_seq_frame_tx_1101;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       dout;
  logic       dout_valid;
  logic       frame_start;
  logic       busy;
  logic [7:0] frame_cnt;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef SEQ_TX_PARITY_EN
  localparam int         FL      = 13;
  localparam logic [12:0] EXP_A5 = {4'b1101, 8'hA5, 1'b0};
  localparam logic [12:0] EXP_00 = {4'b1101, 8'h00, 1'b0};
  localparam logic [12:0] EXP_FF = {4'b1101, 8'hFF, 1'b0};
  localparam logic [12:0] EXP_3C = {4'b1101, 8'h3C, 1'b0};
  localparam logic [12:0] EXP_0D = {4'b1101, 8'h0D, 1'b1};
  localparam logic [12:0] EXP_07 = {4'b1101, 8'h07, 1'b1};
  localparam logic [12:0] EXP_03 = {4'b1101, 8'h03, 1'b0};
  localparam logic [12:0] EXP_FS  = 13'h1000;
  localparam logic [12:0] EXP_VLD = 13'h1FFF;
`else
  localparam int         FL      = 12;
  localparam logic [12:0] EXP_A5 = 13'h0DA5;
  localparam logic [12:0] EXP_00 = 13'h0D00;
  localparam logic [12:0] EXP_FF = 13'h0DFF;
  localparam logic [12:0] EXP_3C = 13'h0D3C;
  localparam logic [12:0] EXP_0D = 13'h0D0D;
  localparam logic [12:0] EXP_FS  = 13'h0800;
  localparam logic [12:0] EXP_VLD = 13'h0FFF;
`endif
  localparam int PER = FL + 3;

  seq_frame_tx_1101 dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accepts one word from IDLE and samples dout, dout_valid and frame_start for FL cycles.
  task automatic send_frame(input logic [7:0] d, output logic [12:0] bits,
                            output logic [12:0] vld, output logic [12:0] fs);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bits = '0;
    vld  = '0;
    fs   = '0;
    for (int i = 0; i < FL; i++) begin
      if (i > 0) tick();
      bits = {bits[11:0], dout};
      vld  = {vld[11:0], dout_valid};
      fs   = {fs[11:0], frame_start};
    end
  endtask

  logic [12:0] bits, vld, fs;
  logic [47:0] got_s, got_v, exp_s, exp_v;
  logic [7:0]  w  [3];
  logic [12:0] ef [3];

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state, including across a clock edge with reset held
    #8;
    chk("rst_state", {in_ready, dout, dout_valid, frame_start, busy, frame_cnt},
        {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    #4 reset_n = 1'b1;
    #1;
    chk("rdy_before_edge", in_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_state", {in_ready, dout, dout_valid, busy, frame_cnt},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    end

    // Single frame 8'hA5
    send_frame(8'hA5, bits, vld, fs);
    chk("a5_bits", bits, EXP_A5);
    chk("a5_vld", vld, EXP_VLD);
    chk("a5_fs", fs, EXP_FS);
    tick();
    chk("a5_gap1", {in_ready, dout, dout_valid, busy, frame_cnt},
        {1'b0, 1'b0, 1'b0, 1'b1, 8'h01});
    tick();
    chk("a5_gap2", {in_ready, dout, dout_valid, busy}, {1'b0, 1'b0, 1'b0, 1'b1});
    tick();
    chk("a5_rdy_back", {in_ready, busy, frame_cnt}, {1'b1, 1'b0, 8'h01});

    // Three back-to-back frames with in_valid held and in_data scrambled while busy
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'h3C;
    ef[0] = EXP_00; ef[1] = EXP_FF; ef[2] = EXP_3C;
    exp_s = '0;
    exp_v = '0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < PER; j++) begin
        exp_s = {exp_s[46:0], (j < FL) ? ef[k][FL-1-j] : 1'b0};
        exp_v = {exp_v[46:0], (j < FL) ? 1'b1 : 1'b0};
      end
    end
    got_s = '0;
    got_v = '0;
    in_data  = w[0];
    in_valid = 1'b1;
    for (int c = 0; c < 3 * PER; c++) begin
      tick();
      got_s = {got_s[46:0], dout};
      got_v = {got_v[46:0], dout_valid};
      if (c == PER - 1) in_data = w[1];
      else if (c == 2 * PER - 1) in_data = w[2];
      else in_data = 8'($urandom);
      if (c == 2 * PER) in_valid = 1'b0;
    end
    chk("b2b_stream", got_s, exp_s);
    chk("b2b_valid", got_v, exp_v);
    chk("b2b_frame_cnt", frame_cnt, 8'd3);
    chk("b2b_idle", {in_ready, busy}, {1'b1, 1'b0});

    // Reset asserted during the third data bit of 8'hC3
    in_data  = 8'hC3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("c3_bit3_live", {dout_valid, busy, frame_cnt}, {1'b1, 1'b1, 8'd3});
    #1 reset_n = 1'b0;
    #1;
    chk("abort_async", {in_ready, dout, dout_valid, busy, frame_cnt},
        {1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    #2 reset_n = 1'b1;
    tick();
    chk("abort_rdy", {in_ready, dout}, {1'b1, 1'b0});
    send_frame(8'h0D, bits, vld, fs);
    chk("0d_bits", bits, EXP_0D);
    chk("0d_vld", vld, EXP_VLD);
    chk("0d_fs", fs, EXP_FS);
    repeat (3) tick();
    chk("0d_done", {in_ready, frame_cnt}, {1'b1, 8'h01});

    // 256 frames of 8'h01: counter reaches 255 then wraps
    #1 reset_n = 1'b0;
    #1;
    chk("wrap_rst_cnt", frame_cnt, 8'h00);
    #1 reset_n = 1'b1;
    tick();
    in_data  = 8'h01;
    in_valid = 1'b1;
    repeat (255 * PER + FL) tick();
    chk("wrap_255", frame_cnt, 8'd255);
    tick();
    in_valid = 1'b0;
    chk("wrap_0", frame_cnt, 8'd0);
    repeat (3) tick();
    chk("wrap_idle", {in_ready, busy}, {1'b1, 1'b0});

`ifdef SEQ_TX_PARITY_EN
    send_frame(8'h07, bits, vld, fs);
    chk("par07_bits", bits, EXP_07);
    chk("par07_vld", vld, EXP_VLD);
    chk("par07_pbit", bits[0], 1'b1);
    repeat (3) tick();
    send_frame(8'h03, bits, vld, fs);
    chk("par03_bits", bits, EXP_03);
    chk("par03_pbit", bits[0], 1'b0);
    repeat (3) tick();
    chk("par_cnt", frame_cnt, 8'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
